// File: rtl/uart_grp_ctrl_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_grp_ctrl_rr_if
// Description : Decoder-side write bus and RX-group read bus of the UART
//               group controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_grp_ctrl_rr_if #(
  parameter int NUM_CH      = 8,
  parameter int GRP_WIDTH   = 4,
  parameter int FIFO_WIDTH  = 51,
  parameter int CFG_WIDTH   = 32,
  parameter int SEL_WIDTH   = 7,
  parameter int LEN_WIDTH   = 7,
  parameter int VALUE_WIDTH = 48
);
  localparam int NUM_GRP = (NUM_CH + GRP_WIDTH - 1) / GRP_WIDTH;

  logic                         uart_grp_en;
  logic                         parallel;
  logic                         cfg;
  logic [SEL_WIDTH-1:0]         slv_sel;
  logic [LEN_WIDTH-1:0]         str_len;
  logic [VALUE_WIDTH-1:0]       value;
  logic                         flag_frame_1;
  logic [NUM_CH-1:0]            uart_dt_fifo_enable;
  logic [NUM_CH*FIFO_WIDTH-1:0] uart_dt_fifo_data;
  logic [NUM_CH*CFG_WIDTH-1:0]  uart_config_bus;
  logic [NUM_CH-1:0]            rd_f_empty;
  logic [NUM_CH*8-1:0]          rd_fifo_data;
  logic [NUM_GRP-1:0]           int_ack;
  logic [NUM_CH-1:0]            rd_fifo_en;
  logic [NUM_GRP-1:0]           interrupt;
  logic                         rd_dv;
  logic [47:0]                  rd_data;

  modport master (
    output uart_grp_en, parallel, cfg, slv_sel, str_len, value, flag_frame_1,
    output rd_f_empty, rd_fifo_data, int_ack,
    input  uart_dt_fifo_enable, uart_dt_fifo_data, uart_config_bus,
    input  rd_fifo_en, interrupt, rd_dv, rd_data
  );

  modport slave (
    input  uart_grp_en, parallel, cfg, slv_sel, str_len, value, flag_frame_1,
    input  rd_f_empty, rd_fifo_data, int_ack,
    output uart_dt_fifo_enable, uart_dt_fifo_data, uart_config_bus,
    output rd_fifo_en, interrupt, rd_dv, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_grp_ctrl_rr.sv
`default_nettype none
// ============================================================================
// Module      : uart_grp_ctrl_rr
// Description : Steers decoded frames to per-channel TX FIFOs / config words
//               and drains debounced RX groups into 48-bit read packets.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_grp_ctrl_rr #(
  parameter int NUM_CH      = 8,
  parameter int GRP_WIDTH   = 4,
  parameter int WAIT_CLKS   = 10,
  parameter int FIFO_WIDTH  = 51,
  parameter int CFG_WIDTH   = 32,
  parameter int CFG_RESET   = 437,
  parameter int SEL_WIDTH   = 7,
  parameter int LEN_WIDTH   = 7,
  parameter int VALUE_WIDTH = 48
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_grp_ctrl_rr_if.slave  bus
);
  localparam int NUM_GRP = (NUM_CH + GRP_WIDTH - 1) / GRP_WIDTH;
  localparam int c_LANES = NUM_GRP * GRP_WIDTH;
  localparam int c_GRP_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int c_CNT_W = $clog2(WAIT_CLKS + 1);
  localparam int c_IDX_W = SEL_WIDTH + 1;
  localparam logic [CFG_WIDTH-1:0] c_CFG_RST = CFG_WIDTH'(CFG_RESET);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_EN   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_DATA = 2'd3
  } state_t;

  // ---------------------------------------------------------------- write path
  logic                         w_frame_ser;
  logic                         w_frame_par;
  logic                         w_frame_cfg;
  logic [2:0]                   w_ser_sel;
  logic [NUM_CH-1:0]            w_wr_en;
  logic [NUM_CH*FIFO_WIDTH-1:0] w_wr_data;
  logic [NUM_CH-1:0]            r_wr_en;
  logic [NUM_CH*FIFO_WIDTH-1:0] r_wr_data;
  logic [NUM_CH*CFG_WIDTH-1:0]  r_cfg;

  always_comb begin
    w_wr_en     = '0;
    w_wr_data   = '0;
    w_frame_cfg = bus.uart_grp_en & bus.cfg;
    w_frame_ser = bus.uart_grp_en & ~bus.cfg & ~bus.parallel;
    w_frame_par = bus.uart_grp_en & ~bus.cfg & bus.parallel;
    if (bus.str_len < LEN_WIDTH'(6)) begin
      w_ser_sel = bus.str_len[2:0];
    end else begin
      w_ser_sel = bus.flag_frame_1 ? 3'b011 : 3'b101;
    end
    // Matching against each real channel index drops out-of-range targets.
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_frame_ser && (bus.slv_sel == SEL_WIDTH'(ch))) begin
        w_wr_en[ch] = 1'b1;
        w_wr_data[ch*FIFO_WIDTH +: FIFO_WIDTH] = FIFO_WIDTH'({w_ser_sel, bus.value});
      end
      for (int i = 0; i < 4; i++) begin
        if (w_frame_par && bus.str_len[i] &&
            (({1'b0, bus.slv_sel} + c_IDX_W'(i)) == c_IDX_W'(ch))) begin
          w_wr_en[ch] = 1'b1;
          w_wr_data[ch*FIFO_WIDTH +: FIFO_WIDTH] = FIFO_WIDTH'(bus.value[8*i +: 8]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= '0;
      r_wr_data <= '0;
      r_cfg     <= {NUM_CH{c_CFG_RST}};
    end else begin
      r_wr_en   <= w_wr_en;
      r_wr_data <= w_wr_data;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_frame_cfg && (bus.slv_sel == SEL_WIDTH'(ch))) begin
          r_cfg[ch*CFG_WIDTH +: CFG_WIDTH] <= bus.value[CFG_WIDTH-1:0];
        end
      end
    end
  end

  assign bus.uart_dt_fifo_enable = r_wr_en;
  assign bus.uart_dt_fifo_data   = r_wr_data;
  assign bus.uart_config_bus     = r_cfg;

  // ----------------------------------------------------------------- read path
  logic [c_LANES-1:0]     w_empty_pad;
  logic [c_LANES*8-1:0]   w_rdata_pad;
  logic [NUM_GRP-1:0]     w_pending;
  logic [c_CNT_W-1:0]     r_cnt [NUM_GRP];
  logic [NUM_GRP-1:0]     r_intr;

  // Lanes past the last channel are padded as permanently empty.
  always_comb begin
    w_empty_pad                = '1;
    w_empty_pad[NUM_CH-1:0]    = bus.rd_f_empty;
    w_rdata_pad                = '0;
    w_rdata_pad[NUM_CH*8-1:0]  = bus.rd_fifo_data;
    for (int g = 0; g < NUM_GRP; g++) begin
      w_pending[g] = ~&w_empty_pad[g*GRP_WIDTH +: GRP_WIDTH];
    end
  end

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_GRP_W-1:0]     r_grp;
  logic [c_GRP_W-1:0]     w_grp_nxt;
  logic [c_GRP_W-1:0]     w_ack_grp;
  logic                   w_ack_hit;
  logic [GRP_WIDTH-1:0]   r_strobe;
  logic [GRP_WIDTH-1:0]   w_strobe_nxt;
  logic [GRP_WIDTH-1:0]   w_lane_empty;
  logic [GRP_WIDTH*8-1:0] w_lane_data;
  logic [GRP_WIDTH*8-1:0] r_bytes;
  logic [GRP_WIDTH*8-1:0] w_bytes_nxt;
  logic [c_LANES-1:0]     w_rd_en_pad;
  logic [47:0]            w_pkt;
  logic                   w_rd_dv;

  // A service clear in RD_EN is written last so it beats a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '{default: '0};
      r_intr <= '0;
    end else begin
      for (int g = 0; g < NUM_GRP; g++) begin
        if (!w_pending[g] || r_intr[g]) begin
          r_cnt[g] <= '0;
        end else if (r_cnt[g] == c_CNT_W'(WAIT_CLKS - 1)) begin
          r_cnt[g]  <= '0;
          r_intr[g] <= 1'b1;
        end else begin
          r_cnt[g] <= r_cnt[g] + 1'b1;
        end
        if ((r_state == S_RD_EN) && (r_grp == c_GRP_W'(g))) begin
          r_intr[g] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_ack_grp    = '0;
    w_ack_hit    = 1'b0;
    w_lane_empty = '1;
    w_lane_data  = '0;
    w_state_nxt  = r_state;
    w_grp_nxt    = r_grp;
    w_strobe_nxt = r_strobe;
    w_bytes_nxt  = r_bytes;
    w_rd_en_pad  = '0;
    for (int g = NUM_GRP - 1; g >= 0; g--) begin
      if (bus.int_ack[g]) begin
        w_ack_grp = c_GRP_W'(g);
        w_ack_hit = r_intr[g];
      end
    end
    for (int g = 0; g < NUM_GRP; g++) begin
      if (r_grp == c_GRP_W'(g)) begin
        w_lane_empty = w_empty_pad[g*GRP_WIDTH +: GRP_WIDTH];
        w_lane_data  = w_rdata_pad[g*GRP_WIDTH*8 +: GRP_WIDTH*8];
      end
    end
    case (r_state)
      S_IDLE: begin
        if (w_ack_hit) begin
          w_grp_nxt   = w_ack_grp;
          w_state_nxt = S_RD_EN;
        end
      end
      S_RD_EN: begin
        for (int g = 0; g < NUM_GRP; g++) begin
          if (r_grp == c_GRP_W'(g)) begin
            w_rd_en_pad[g*GRP_WIDTH +: GRP_WIDTH] = ~w_lane_empty;
          end
        end
        w_strobe_nxt = ~w_lane_empty;
        w_state_nxt  = (&w_lane_empty) ? S_IDLE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        for (int k = 0; k < GRP_WIDTH; k++) begin
          w_bytes_nxt[8*k +: 8] = r_strobe[k] ? w_lane_data[8*k +: 8] : 8'h00;
        end
        w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grp    <= '0;
      r_strobe <= '0;
      r_bytes  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grp    <= w_grp_nxt;
      r_strobe <= w_strobe_nxt;
      r_bytes  <= w_bytes_nxt;
    end
  end

  always_comb begin
    w_pkt                      = '0;
    w_pkt[GRP_WIDTH*8-1:0]     = r_bytes;
    w_pkt[38:32]               = 7'(r_strobe);
    w_pkt[39]                  = 1'b1;
    w_pkt[46:40]               = 7'(32'(r_grp) * GRP_WIDTH);
  end

  assign w_rd_dv        = (r_state == S_RD_DATA);
  assign bus.rd_dv      = w_rd_dv;
  assign bus.rd_data    = w_rd_dv ? w_pkt : 48'h0;
  assign bus.rd_fifo_en = w_rd_en_pad[NUM_CH-1:0];
  assign bus.interrupt  = r_intr;
endmodule
`default_nettype wire

// File: tb/tb_uart_grp_ctrl_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_grp_ctrl_rr
// Description : Self-checking bench for uart_grp_ctrl_rr with an RX FIFO and
//               frame-steering reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_grp_ctrl_rr;
  localparam int NUM_CH    = 8;
  localparam int GRP_WIDTH = 4;
  localparam int WAIT_CLKS = 10;
  localparam int NUM_GRP   = 2;
  localparam int FW        = 51;
  localparam int CW        = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_grp_ctrl_rr_if #(.NUM_CH(NUM_CH), .GRP_WIDTH(GRP_WIDTH)) bus ();

  uart_grp_ctrl_rr #(
    .NUM_CH(NUM_CH), .GRP_WIDTH(GRP_WIDTH), .WAIT_CLKS(WAIT_CLKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [31:0] cfg_m [NUM_CH];
  logic [7:0]  q_mem [NUM_CH][4];
  int          q_cnt [NUM_CH];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_empty();
    for (int ch = 0; ch < NUM_CH; ch++) bus.rd_f_empty[ch] = (q_cnt[ch] == 0);
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    q_mem[ch][q_cnt[ch]] = b;
    q_cnt[ch]++;
    drive_empty();
  endtask

  // One clock; the RX FIFO model pops on the strobe seen before the edge.
  task automatic tick();
    logic [NUM_CH-1:0] pop;
    pop = bus.rd_fifo_en;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (pop[ch] && q_cnt[ch] > 0) begin
        bus.rd_fifo_data[ch*8 +: 8] = q_mem[ch][0];
        for (int j = 0; j < 3; j++) q_mem[ch][j] = q_mem[ch][j+1];
        q_cnt[ch]--;
      end
    end
    drive_empty();
  endtask

  function automatic logic [NUM_CH*CW-1:0] cfg_vec();
    logic [NUM_CH*CW-1:0] v;
    for (int ch = 0; ch < NUM_CH; ch++) v[ch*CW +: CW] = cfg_m[ch];
    return v;
  endfunction

  task automatic frame(input logic en, input logic par, input logic cf, input logic [6:0] sel,
                       input logic [6:0] len, input logic flag, input logic [47:0] val);
    logic [NUM_CH-1:0]    e_en;
    logic [NUM_CH*FW-1:0] e_data;
    logic [2:0]           s;
    e_en   = '0;
    e_data = '0;
    bus.uart_grp_en  = en;
    bus.parallel     = par;
    bus.cfg          = cf;
    bus.slv_sel      = sel;
    bus.str_len      = len;
    bus.flag_frame_1 = flag;
    bus.value        = val;
    if (en && cf) begin
      if (sel < NUM_CH) cfg_m[sel] = val[31:0];
    end else if (en && par) begin
      for (int i = 0; i < 4; i++) begin
        if (len[i] && (sel + i < NUM_CH)) begin
          e_en[sel+i] = 1'b1;
          e_data[(sel+i)*FW +: FW] = {43'b0, val[8*i +: 8]};
        end
      end
    end else if (en) begin
      if (sel < NUM_CH) begin
        s = (len < 6) ? len[2:0] : (flag ? 3'd3 : 3'd5);
        e_en[sel] = 1'b1;
        e_data[sel*FW +: FW] = {s, val};
      end
    end
    tick();
    bus.uart_grp_en = 1'b0;
    chk("wr_en", bus.uart_dt_fifo_enable, e_en);
    chk("wr_data", bus.uart_dt_fifo_data, e_data);
    chk("cfg_bus", bus.uart_config_bus, cfg_vec());
    tick();
    chk("wr_en_idle", bus.uart_dt_fifo_enable, '0);
    chk("wr_data_idle", bus.uart_dt_fifo_data, '0);
  endtask

  // Acknowledge group g while its interrupt is up and check the whole read.
  task automatic service(input logic [NUM_GRP-1:0] ack, input int g);
    logic [GRP_WIDTH-1:0] stb;
    logic [47:0]          pkt;
    logic [NUM_CH-1:0]    en_e;
    int                   ch;
    stb  = '0;
    pkt  = '0;
    en_e = '0;
    for (int k = 0; k < GRP_WIDTH; k++) begin
      ch = g * GRP_WIDTH + k;
      if (ch < NUM_CH && q_cnt[ch] > 0) begin
        stb[k]         = 1'b1;
        en_e[ch]       = 1'b1;
        pkt[8*k +: 8]  = q_mem[ch][0];
      end
    end
    pkt[38:32] = {3'b0, stb};
    pkt[39]    = 1'b1;
    pkt[46:40] = 7'(g * GRP_WIDTH);
    bus.int_ack = ack;
    tick();
    bus.int_ack = '0;
    chk("rd_fifo_en", bus.rd_fifo_en, en_e);
    tick();
    chk("int_cleared", bus.interrupt[g], 1'b0);
    chk("rd_fifo_en_off", bus.rd_fifo_en, '0);
    chk("rd_dv_wait", bus.rd_dv, 1'b0);
    tick();
    chk("rd_dv", bus.rd_dv, 1'b1);
    chk("rd_data", bus.rd_data, pkt);
    tick();
    chk("rd_dv_end", bus.rd_dv, 1'b0);
    chk("rd_data_end", bus.rd_data, '0);
  endtask

  initial begin
    logic [NUM_GRP-1:0] one_g;
    logic [NUM_GRP-1:0] ack;
    int                 g;
    int                 any;
    bus.uart_grp_en  = 1'b0;
    bus.parallel     = 1'b0;
    bus.cfg          = 1'b0;
    bus.slv_sel      = '0;
    bus.str_len      = '0;
    bus.value        = '0;
    bus.flag_frame_1 = 1'b0;
    bus.int_ack      = '0;
    bus.rd_fifo_data = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      q_cnt[ch] = 0;
      cfg_m[ch] = 32'd437;
    end
    drive_empty();

    rst = 1'b1;
    repeat (2) tick();
    chk("rst_cfg", bus.uart_config_bus, cfg_vec());
    chk("rst_wr_en", bus.uart_dt_fifo_enable, '0);
    chk("rst_wr_data", bus.uart_dt_fifo_data, '0);
    chk("rst_rd_fifo_en", bus.rd_fifo_en, '0);
    chk("rst_interrupt", bus.interrupt, '0);
    chk("rst_rd_dv", bus.rd_dv, 1'b0);
    chk("rst_rd_data", bus.rd_data, '0);
    rst = 1'b0;

    // Directed write frames
    frame(1'b1, 1'b0, 1'b1, 7'd3, 7'd0, 1'b0, 48'h1C200);
    frame(1'b1, 1'b0, 1'b0, 7'd2, 7'd7, 1'b1, 48'hA5);
    frame(1'b1, 1'b0, 1'b0, 7'd2, 7'd4, 1'b1, 48'hA5);
    frame(1'b1, 1'b1, 1'b0, 7'd6, 7'b0001111, 1'b0, 48'h44332211);
    frame(1'b1, 1'b0, 1'b0, 7'd9, 7'd2, 1'b0, 48'h123);
    frame(1'b1, 1'b0, 1'b1, 7'd8, 7'd0, 1'b0, 48'hDEAD);

    // Channels 4 and 6 pending from the first cycle
    push(4, 8'h4C);
    push(6, 8'h6E);
    repeat (WAIT_CLKS - 1) tick();
    chk("int_early", bus.interrupt, 2'b00);
    tick();
    chk("int_grp1", bus.interrupt, 2'b10);
    service(2'b10, 1);

    // Ack to a non-interrupting group does nothing
    bus.int_ack = 2'b01;
    repeat (4) begin
      tick();
      chk("ign_rd_fifo_en", bus.rd_fifo_en, '0);
      chk("ign_rd_dv", bus.rd_dv, 1'b0);
    end
    bus.int_ack = '0;

    // Reset during RD_WAIT aborts the read
    push(1, 8'h11);
    repeat (WAIT_CLKS) tick();
    chk("int_grp0", bus.interrupt, 2'b01);
    bus.int_ack = 2'b01;
    tick();
    bus.int_ack = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rd_dv", bus.rd_dv, 1'b0);
    chk("abort_int", bus.interrupt, '0);
    tick();
    chk("abort_rd_dv2", bus.rd_dv, 1'b0);
    chk("abort_rd_data", bus.rd_data, '0);
    chk("abort_int2", bus.interrupt, '0);
    for (int ch = 0; ch < NUM_CH; ch++) cfg_m[ch] = 32'd437;
    chk("abort_cfg", bus.uart_config_bus, cfg_vec());

    // Debounce restarts when pending drops early
    push(0, 8'h5A);
    repeat (5) tick();
    chk("deb_short", bus.interrupt, '0);
    q_cnt[0] = 0;
    drive_empty();
    repeat (3) tick();
    push(0, 8'hC3);
    repeat (WAIT_CLKS - 1) tick();
    chk("deb_early", bus.interrupt, '0);
    tick();
    chk("deb_fire", bus.interrupt, 2'b01);
    service(2'b11, 0);

    // Randomized write frames
    for (int n = 0; n < 40; n++) begin
      frame(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            7'($urandom_range(0, 11)), 7'($urandom), 1'($urandom),
            {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    end

    // Randomized group reads, including re-pend after service
    for (int r = 0; r < 8; r++) begin
      g     = $urandom_range(0, NUM_GRP - 1);
      one_g = '0;
      one_g[g] = 1'b1;
      any   = 0;
      for (int k = 0; k < GRP_WIDTH; k++) begin
        int d;
        d = $urandom_range(0, 2);
        if (k == GRP_WIDTH - 1 && any == 0) d = 1;
        for (int j = 0; j < d; j++) push(g * GRP_WIDTH + k, 8'($urandom));
        any += d;
      end
      repeat (WAIT_CLKS - 1) tick();
      chk("rnd_int_early", bus.interrupt, '0);
      tick();
      chk("rnd_int", bus.interrupt, one_g);
      for (int s = 0; s < 3; s++) begin
        ack = (NUM_GRP'($urandom) << (g + 1)) | one_g;
        service(ack, g);
        any = 0;
        for (int k = 0; k < GRP_WIDTH; k++) any += q_cnt[g * GRP_WIDTH + k];
        if (any == 0) break;
        repeat (WAIT_CLKS - 3) tick();
        chk("rnd_repend_early", bus.interrupt, '0);
        tick();
        chk("rnd_repend", bus.interrupt, one_g);
      end
      repeat (WAIT_CLKS + 2) tick();
      chk("rnd_drained", bus.interrupt, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_grp_ctrl_rr.md
# uart_grp_ctrl_rr

Parametrised UART group controller. It sits between the frame decoder/encoder and a bank of `NUM_CH` UART channels. On the write side it steers decoded serial, parallel and configuration frames into per-channel TX FIFO strobes and config registers. On the read side it groups RX FIFOs into `GRP_WIDTH`-wide groups, raises a per-group debounced interrupt, and on acknowledge drains one group into a single 48-bit read packet. It adds a synchronous reset, independent per-group wait counters, range-checked writes and correct per-lane read indexing.

## Interface
- `NUM_CH`, 8: number of UART channels, 1..64.
- `GRP_WIDTH`, 4: channels per read group, 1..4.
- `NUM_GRP`, derived, `(NUM_CH+GRP_WIDTH-1)/GRP_WIDTH`: group count.
- `WAIT_CLKS`, 10: consecutive pending cycles before an interrupt asserts, ≥1.
- `FIFO_WIDTH`, 51: TX FIFO word width, 48 data + 3 select.
- `CFG_WIDTH`, 32: per-channel config word width.
- `CFG_RESET`, 437: reset value of every config word.
- `SEL_WIDTH`, 7 / `LEN_WIDTH`, 7 / `VALUE_WIDTH`, 48: decoder field widths.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `uart_grp_en` in 1: decoder frame targets this block.
- `parallel` in 1: parallel-mode frame.
- `cfg` in 1: configuration frame.
- `slv_sel` in SEL_WIDTH: base channel index.
- `str_len` in LEN_WIDTH: serial length, or parallel strobe in bits [3:0].
- `value` in 48: frame payload.
- `flag_frame_1` in 1: first frame of a long serial string.
- `uart_dt_fifo_enable` out NUM_CH: TX FIFO write strobe per channel.
- `uart_dt_fifo_data` out NUM_CH*51: TX FIFO write words.
- `uart_config_bus` out NUM_CH*32: config words.
- `rd_f_empty` in NUM_CH: RX FIFO empty flags.
- `rd_fifo_data` in NUM_CH*8: RX FIFO read data, valid 1 cycle after `rd_fifo_en`.
- `int_ack` in NUM_GRP: acknowledge per group.
- `rd_fifo_en` out NUM_CH: RX FIFO read strobe.
- `interrupt` out NUM_GRP: per-group interrupt request.
- `rd_dv` out 1: read packet valid, one-cycle pulse.
- `rd_data` out 48: read packet; 0 whenever `rd_dv`=0. No tristate.

## Operation
- Reset: all outputs 0 except `uart_config_bus`, where every word is `CFG_RESET`. FSM goes to IDLE, all counters go to 0. Reset aborts any read in progress, and no `rd_dv` is emitted.
- Write path is registered. `uart_dt_fifo_enable` and `uart_dt_fifo_data` are one-cycle pulses and are 0 in every cycle without a qualifying frame.
- Serial (`uart_grp_en`=1, `cfg`=0, `parallel`=0): channel `slv_sel` gets enable=1 and word = {sel, value}.
  - sel = `str_len[2:0]` if `str_len`<6.
  - Otherwise sel = `flag_frame_1` ? 3'b011 : 3'b101.
- Parallel: for i=0..3, if `str_len[i]` and `slv_sel+i`<NUM_CH, channel `slv_sel+i` gets enable=1 and word = {43'b0, value[8i+7:8i]}.
- Config (`uart_grp_en`=1, `cfg`=1): word `slv_sel` = `value[31:0]`. Config words hold their value otherwise.
- Out-of-range channels: any write with `slv_sel`≥NUM_CH, or lanes beyond NUM_CH, is dropped silently.
- Group lanes: group g owns channels g*GRP_WIDTH+k for k<GRP_WIDTH. Lanes ≥NUM_CH are treated as empty.
- Pending: pending[g] = OR of ~`rd_f_empty` over the group's valid lanes.
- Counter cnt[g] (independent per group):
  - Clears while pending[g]=0 or `interrupt[g]`=1.
  - Otherwise increments.
  - When cnt[g] reaches WAIT_CLKS-1 with pending still 1, `interrupt[g]` sets next cycle.
- `interrupt[g]` holds until group g is serviced.
- Read FSM:
  - IDLE: if `int_ack`≠0, take the lowest set bit g. If `interrupt[g]`=1, latch g and go to RD_EN. Acks for non-interrupting groups are ignored.
  - RD_EN: `rd_fifo_en` lane = ~empty for each valid lane of g (one cycle). Latch strobe[GRP_WIDTH-1:0]. Clear `interrupt[g]`. If strobe=0, return to IDLE with no packet; otherwise go to RD_WAIT.
  - RD_WAIT: `rd_fifo_en`=0. Go to RD_DATA.
  - RD_DATA: `rd_dv`=1. Packet fields:
    - [8k+7:8k] = `rd_fifo_data` of channel g*GRP_WIDTH+k if strobe[k], else 0.
    - [38:32] = zero-extended strobe.
    - [39] = 1.
    - [46:40] = g*GRP_WIDTH.
    - [47] = 0.
    - Then go to IDLE.

## Timing
- Write frame sampled at cycle n appears on the outputs at n+1, and is 0 at n+2 unless another frame arrives.
- Interrupt: pending rising at cycle n (sampled) gives `interrupt` high at n+WAIT_CLKS. Pending dropping before that restarts the count.
- Read: ack sampled in IDLE at cycle n gives:
  - `rd_fifo_en` at n+1.
  - `interrupt[g]` low from n+2.
  - `rd_dv` at n+3.
  - Next ack is accepted at n+4.
- Acks arriving outside IDLE are ignored; the requester must hold or re-assert.
- Simultaneous clear and re-pend: the clear wins. If data remains, the interrupt re-asserts WAIT_CLKS cycles after the clear.
- Write path and read path run concurrently without interaction.

## Test plan
- Reset with NUM_CH=8: every config word = 437, all outputs 0. Then cfg write slv_sel=3, value=0x1C200 → word 3 = 0x0001C200 one cycle later; other words stay 437.
- Serial, slv_sel=2, str_len=7, flag_frame_1=1, value=0xA5 → enable=8'b00000100 for 1 cycle, word2[50:48]=3'b011, word2[47:0]=0xA5. Repeat with str_len=4 → sel=3'b100.
- Parallel, slv_sel=6, str_len=4'b1111, value=0x44332211 (NUM_CH=8) → enable=8'b11000000, word6=0x11, word7=0x22; lanes 8 and 9 dropped.
- Channels 4 and 6 non-empty from cycle 0, WAIT_CLKS=10 → `interrupt`=2'b10 at cycle 10. Ack 2'b10 → `rd_fifo_en`=8'b01010000 for one cycle; `rd_dv` 3 cycles after the ack; rd_data = {0, 7'd4, 1, 7'b0000101, 8'h00, byte6, 8'h00, byte4}.
- Ack to a group whose interrupt is low → no `rd_fifo_en`, no `rd_dv`. Assert `rst` during RD_WAIT → no `rd_dv` and all interrupts clear.
- Group 0 pending for 5 cycles, then empty, then pending again → interrupt only after 10 fresh consecutive cycles.
